// File: rtl/l2_main_mem_ctrl.sv
// l2_main_mem_ctrl: line-granular backing-store model behind the L2 cache.
// Serves one request at a time with a fixed read/write latency, keeps
// read/write/drop statistics.
// Optional build macro L2_MAIN_MEM_RANGE_CHECK_EN: flags out-of-range
// addresses on mem_err_o instead of letting the line index wrap.
module l2_main_mem_ctrl #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned LINE_W      = 128,
    parameter int unsigned DEPTH_LINES = 1024,
    parameter int unsigned RD_LATENCY  = 8,
    parameter int unsigned WR_LATENCY  = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] mem_req_addr_i,
    input  logic [LINE_W-1:0] mem_req_data_i,
    input  logic              mem_req_rw_i,
    input  logic              mem_req_valid_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic              mem_ready_o,
    output logic              busy_o,
    output logic [31:0]       no_rd_o,
    output logic [31:0]       no_wr_o,
    output logic [31:0]       no_drop_o
`ifdef L2_MAIN_MEM_RANGE_CHECK_EN
    ,
    output logic              mem_err_o
`endif
);

    localparam int unsigned OFF_W   = 4;
    localparam int unsigned IDX_W   = $clog2(DEPTH_LINES);
    localparam int unsigned LAT_MAX = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int unsigned CNT_W   = (LAT_MAX > 1) ? $clog2(LAT_MAX) : 1;
    localparam logic [CNT_W-1:0] RD_CNT_INIT = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] WR_CNT_INIT = CNT_W'(WR_LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    req_idx_q, req_idx_d;
    logic [LINE_W-1:0]   req_data_q, req_data_d;
    logic                req_rw_q, req_rw_d;
    logic                req_oor_q, req_oor_d;
    logic                ready_q, ready_d;
    logic                busy_q, busy_d;
    logic [LINE_W-1:0]   data_q, data_d;
    logic [31:0]         no_rd_q, no_rd_d;
    logic [31:0]         no_wr_q, no_wr_d;
    logic [31:0]         no_drop_q, no_drop_d;
    logic                err_q, err_d;

    logic [LINE_W-1:0]   mem_array_q [DEPTH_LINES];
    logic                mem_we;
    logic [IDX_W-1:0]    in_idx;
    logic                in_oor;
    logic [LINE_W-1:0]   rd_line;
    logic [CNT_W-1:0]    lat_init;
    logic                unused_addr;

    // Request decode: line index from the byte address, out-of-range flag
    assign in_idx = mem_req_addr_i[IDX_W+OFF_W-1:OFF_W];
`ifdef L2_MAIN_MEM_RANGE_CHECK_EN
    assign in_oor      = |mem_req_addr_i[ADDR_W-1:IDX_W+OFF_W];
    assign unused_addr = ^mem_req_addr_i[OFF_W-1:0];
`else
    assign in_oor      = 1'b0;
    assign unused_addr = ^{mem_req_addr_i[ADDR_W-1:IDX_W+OFF_W], mem_req_addr_i[OFF_W-1:0]};
`endif

    // Pending write commits at the end of its response cycle; reset aborts it
    assign mem_we = (state_q == ST_RESP) && req_rw_q && !req_oor_q && !rst_i;

    // Array read for a fill, forwarding a write committing on the same edge
    always_comb begin
        rd_line = mem_array_q[req_idx_d];
        if ((state_q == ST_RESP) && req_rw_q && !req_oor_q && (req_idx_q == req_idx_d)) begin
            rd_line = req_data_q;
        end
        if (req_oor_d) begin
            rd_line = '0;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_idx_d  = req_idx_q;
        req_data_d = req_data_q;
        req_rw_d   = req_rw_q;
        req_oor_d  = req_oor_q;
        data_d     = data_q;
        no_rd_d    = no_rd_q;
        no_wr_d    = no_wr_q;
        no_drop_d  = no_drop_q;
        ready_d    = 1'b0;
        busy_d     = 1'b0;
        err_d      = 1'b0;
        lat_init   = mem_req_rw_i ? WR_CNT_INIT : RD_CNT_INIT;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (mem_req_valid_i) begin
                    req_idx_d  = in_idx;
                    req_data_d = mem_req_data_i;
                    req_rw_d   = mem_req_rw_i;
                    req_oor_d  = in_oor;
                    cnt_d      = lat_init;
                    state_d    = (lat_init != '0) ? ST_WAIT : ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (mem_req_valid_i) begin
                    no_drop_d = no_drop_q + 32'd1;
                end
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_WAIT);
        if (state_d == ST_RESP) begin
            ready_d = 1'b1;
            err_d   = req_oor_d;
            if (req_rw_d) begin
                no_wr_d = no_wr_q + 32'd1;
            end else begin
                no_rd_d = no_rd_q + 32'd1;
                data_d  = rd_line;
            end
        end
    end

    // State, request and output registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            req_idx_q  <= '0;
            req_data_q <= '0;
            req_rw_q   <= 1'b0;
            req_oor_q  <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            data_q     <= '0;
            no_rd_q    <= '0;
            no_wr_q    <= '0;
            no_drop_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_idx_q  <= req_idx_d;
            req_data_q <= req_data_d;
            req_rw_q   <= req_rw_d;
            req_oor_q  <= req_oor_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            data_q     <= data_d;
            no_rd_q    <= no_rd_d;
            no_wr_q    <= no_wr_d;
            no_drop_q  <= no_drop_d;
            err_q      <= err_d;
        end
    end

    // Backing array, deliberately not cleared by reset
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_array_q[req_idx_q] <= req_data_q;
        end
    end

    assign mem_data_o  = data_q;
    assign mem_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign no_rd_o     = no_rd_q;
    assign no_wr_o     = no_wr_q;
    assign no_drop_o   = no_drop_q;
`ifdef L2_MAIN_MEM_RANGE_CHECK_EN
    assign mem_err_o   = err_q;
`else
    logic unused_err;
    assign unused_err  = err_q ^ unused_addr;
`endif

endmodule

// File: tb/tb_l2_main_mem_ctrl.sv
// Bench for l2_main_mem_ctrl: vector table driven through a scoreboard on the
// default-latency instance, hand sequences for back-to-back, drop, reset and
// the single-cycle-latency instance.
module tb_l2_main_mem_ctrl;

    localparam int unsigned LAT = 8;
`ifdef L2_MAIN_MEM_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    localparam logic [127:0] D1 = 128'h1111_1111_1111_1111_2222_2222_2222_2222;
    localparam logic [127:0] D2 = 128'h3333_3333_4444_4444_5555_5555_6666_6666;
    localparam logic [127:0] D3 = 128'hDEAD_BEEF_0000_0001_CAFE_F00D_8000_0000;
    localparam logic [127:0] D4 = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;
    localparam logic [127:0] D5 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    localparam logic [127:0] D6 = 128'h7777_0000_7777_0000_7777_0000_7777_0000;
    localparam logic [127:0] DA = 128'hAAAA_0000_0000_0000_0000_0000_0000_AAAA;
    localparam logic [127:0] DB = 128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB;
    localparam logic [127:0] DP = 128'h9999_8888_7777_6666_5555_4444_3333_2222;
    localparam logic [127:0] DX = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic [31:0]  mem_req_addr_i = '0;
    logic [127:0] mem_req_data_i = '0;
    logic         mem_req_rw_i = 1'b0;
    logic         mem_req_valid_i = 1'b0;
    logic [127:0] mem_data_o;
    logic         mem_ready_o, busy_o;
    logic [31:0]  no_rd_o, no_wr_o, no_drop_o;

    logic [31:0]  f_addr = '0;
    logic [127:0] f_wdata = '0;
    logic         f_rw = 1'b0;
    logic         f_valid = 1'b0;
    logic [127:0] f_data;
    logic         f_ready, f_busy;
    logic [31:0]  f_no_rd, f_no_wr, f_no_drop;
`ifdef L2_MAIN_MEM_RANGE_CHECK_EN
    logic         mem_err_o, f_err;
`endif

    always #5 clk = ~clk;

    l2_main_mem_ctrl u_dut (
        .clk_i(clk), .rst_i(rst_i),
        .mem_req_addr_i(mem_req_addr_i), .mem_req_data_i(mem_req_data_i),
        .mem_req_rw_i(mem_req_rw_i), .mem_req_valid_i(mem_req_valid_i),
        .mem_data_o(mem_data_o), .mem_ready_o(mem_ready_o), .busy_o(busy_o),
        .no_rd_o(no_rd_o), .no_wr_o(no_wr_o), .no_drop_o(no_drop_o)
`ifdef L2_MAIN_MEM_RANGE_CHECK_EN
        , .mem_err_o(mem_err_o)
`endif
    );

    l2_main_mem_ctrl #(.RD_LATENCY(1), .WR_LATENCY(1)) u_fast (
        .clk_i(clk), .rst_i(rst_i),
        .mem_req_addr_i(f_addr), .mem_req_data_i(f_wdata),
        .mem_req_rw_i(f_rw), .mem_req_valid_i(f_valid),
        .mem_data_o(f_data), .mem_ready_o(f_ready), .busy_o(f_busy),
        .no_rd_o(f_no_rd), .no_wr_o(f_no_wr), .no_drop_o(f_no_drop)
`ifdef L2_MAIN_MEM_RANGE_CHECK_EN
        , .mem_err_o(f_err)
`endif
    );

    typedef struct {
        logic [31:0]  addr;
        logic [127:0] data;
        logic         rw;
        logic [127:0] exp;
        logic         err;
    } vec_t;

    typedef struct {
        logic         rw;
        logic [127:0] data;
        logic         err;
        int unsigned  due;
    } sb_t;

    sb_t          sb_q[$];
    sb_t          mon_e;
    vec_t         vt[12];
    vec_t         fv[8];
    int unsigned  cyc = 0;
    int           checks = 0;
    int           failures = 0;
    int unsigned  exp_rd = 0;
    int unsigned  exp_wr = 0;
    logic [127:0] last_rd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard on every ready pulse
    always @(negedge clk) begin
        if (!rst_i && mem_ready_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready: got ready=1 expected no response at cycle %0d", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                check("latency", 128'(cyc), 128'(mon_e.due));
                check("busy_in_resp", 128'(busy_o), 128'(0));
                if (mon_e.rw) begin
                    exp_wr++;
                    check("data_held_on_wr", mem_data_o, last_rd);
                end else begin
                    exp_rd++;
                    check("rd_data", mem_data_o, mon_e.data);
                    last_rd = mon_e.data;
                end
                check("no_rd", 128'(no_rd_o), 128'(exp_rd));
                check("no_wr", 128'(no_wr_o), 128'(exp_wr));
`ifdef L2_MAIN_MEM_RANGE_CHECK_EN
                check("mem_err", 128'(mem_err_o), 128'(mon_e.err));
`endif
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [127:0] d, input logic rw,
                         input logic [127:0] exp, input logic err, input bit push);
        sb_t e;
        mem_req_addr_i  = a;
        mem_req_data_i  = d;
        mem_req_rw_i    = rw;
        mem_req_valid_i = 1'b1;
        if (push) begin
            e.rw   = rw;
            e.data = exp;
            e.err  = err;
            e.due  = cyc + LAT;
            sb_q.push_back(e);
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0) break;
        end
        check("drain_timeout", 128'(sb_q.size()), 128'(0));
        sb_q.delete();
    endtask

    task automatic issue_one(input logic [31:0] a, input logic [127:0] d, input logic rw,
                             input logic [127:0] exp, input logic err);
        @(negedge clk);
        drive(a, d, rw, exp, err, 1'b1);
        @(negedge clk);
        mem_req_valid_i = 1'b0;
        wait_drain();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 128'(mem_ready_o), 128'(0));
        check({tag, "_busy"},  128'(busy_o), 128'(0));
        check({tag, "_data"},  mem_data_o, 128'(0));
        check({tag, "_no_rd"}, 128'(no_rd_o), 128'(0));
        check({tag, "_no_wr"}, 128'(no_wr_o), 128'(0));
        check({tag, "_no_drop"}, 128'(no_drop_o), 128'(0));
`ifdef L2_MAIN_MEM_RANGE_CHECK_EN
        check({tag, "_err"}, 128'(mem_err_o), 128'(0));
`endif
    endtask

    initial begin
        // Table: {addr, write data, rw, expected read data, expected err}
        vt[0]  = '{32'h0000_0040, D1, 1'b1, '0, 1'b0};
        vt[1]  = '{32'h0000_0040, '0, 1'b0, D1, 1'b0};
        vt[2]  = '{32'h0000_0050, D2, 1'b1, '0, 1'b0};
        vt[3]  = '{32'h0000_1040, D3, 1'b1, '0, 1'b0};
        vt[4]  = '{32'h0000_0050, '0, 1'b0, D2, 1'b0};
        vt[5]  = '{32'h0000_1040, '0, 1'b0, D3, 1'b0};
        vt[6]  = '{32'h0000_0040, D4, 1'b1, '0, 1'b0};
        vt[7]  = '{32'h0000_004F, '0, 1'b0, D4, 1'b0};
        vt[8]  = '{32'h0000_0000, D5, 1'b1, '0, 1'b0};
        vt[9]  = '{32'h0001_0000, '0, 1'b0, RC ? 128'(0) : D5, RC};
        vt[10] = '{32'h0001_0000, D6, 1'b1, '0, RC};
        vt[11] = '{32'h0000_0000, '0, 1'b0, RC ? D5 : D6, 1'b0};

        // Single-cycle-latency instance: back-to-back ops incl. write-then-read of one line
        fv[0] = '{32'h00, 128'hF0, 1'b1, '0, 1'b0};
        fv[1] = '{32'h10, 128'hF1, 1'b1, '0, 1'b0};
        fv[2] = '{32'h20, 128'hF2, 1'b1, '0, 1'b0};
        fv[3] = '{32'h30, 128'hF3, 1'b1, '0, 1'b0};
        fv[4] = '{32'h30, '0, 1'b0, 128'hF3, 1'b0};
        fv[5] = '{32'h00, '0, 1'b0, 128'hF0, 1'b0};
        fv[6] = '{32'h10, '0, 1'b0, 128'hF1, 1'b0};
        fv[7] = '{32'h20, '0, 1'b0, 128'hF2, 1'b0};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_i = 1'b0;

        for (int i = 0; i < 12; i++) begin
            issue_one(vt[i].addr, vt[i].data, vt[i].rw, vt[i].exp, vt[i].err);
        end
        check("no_drop_idle", 128'(no_drop_o), 128'(0));

        // Write-back then fill issued in the write's ready cycle, no bubble
        @(negedge clk);
        drive(32'h80, DA, 1'b1, '0, 1'b0, 1'b1);
        @(negedge clk);
        mem_req_valid_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (mem_ready_o) break;
        end
        check("b2b_wr_ready", 128'(mem_ready_o), 128'(1));
        check("b2b_busy", 128'(busy_o), 128'(0));
        drive(32'h80, '0, 1'b0, DA, 1'b0, 1'b1);
        @(negedge clk);
        mem_req_valid_i = 1'b0;
        check("b2b_accepted", 128'(busy_o), 128'(1));
        wait_drain();

        // Request while busy is dropped and counted
        @(negedge clk);
        drive(32'h40, '0, 1'b0, D4, 1'b0, 1'b1);
        @(negedge clk);
        mem_req_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        drive(32'h40, DX, 1'b1, '0, 1'b0, 1'b0);
        @(negedge clk);
        mem_req_valid_i = 1'b0;
        wait_drain();
        check("no_drop", 128'(no_drop_o), 128'(1));
        issue_one(32'h40, '0, 1'b0, D4, 1'b0);

        // Reset in the middle of a write aborts it
        issue_one(32'h100, DP, 1'b1, '0, 1'b0);
        @(negedge clk);
        drive(32'h100, DB, 1'b1, '0, 1'b0, 1'b1);
        @(negedge clk);
        mem_req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy", 128'(busy_o), 128'(1));
        rst_i = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check_reset_outputs("midrst");
        rst_i   = 1'b0;
        exp_rd  = 0;
        exp_wr  = 0;
        last_rd = '0;
        issue_one(32'h100, '0, 1'b0, DP, 1'b0);

        // Single-cycle latency: each request answered on the next cycle
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("fast_ready", 128'(f_ready), 128'(1));
                check("fast_busy", 128'(f_busy), 128'(0));
                if (!fv[i-1].rw) check("fast_rd_data", f_data, fv[i-1].exp);
            end
            if (i < 8) begin
                f_addr  = fv[i].addr;
                f_wdata = fv[i].data;
                f_rw    = fv[i].rw;
                f_valid = 1'b1;
            end else begin
                f_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("fast_idle_ready", 128'(f_ready), 128'(0));
        check("fast_no_wr", 128'(f_no_wr), 128'(4));
        check("fast_no_rd", 128'(f_no_rd), 128'(4));
        check("fast_no_drop", 128'(f_no_drop), 128'(0));

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/l2_main_mem_ctrl.md
Name: l2_main_mem_ctrl

Overview:
- Backing-store memory controller sitting directly downstream of the L2 cache controller.
- Consumes its line-granular memory request (addr, 128-bit line, rw, valid) and returns a line response (data, ready) after a fixed, parameterised latency.
- Models main memory as a line-wide array, serialises one request at a time, and keeps access statistics for the cache performance counters.

Parameters:
- ADDR_W, 32, request address width.
- LINE_W, 128, cache line width in bits (16-byte lines; line offset is addr[3:0]).
- DEPTH_LINES, 1024, number of lines in the backing array (power of two).
- RD_LATENCY, 8, cycles from read-request acceptance to ready pulse (>=1).
- WR_LATENCY, 8, cycles from write-request acceptance to ready pulse (>=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- mem_req_addr_i  in  ADDR_W  line address (byte address; bits [3:0] ignored).
- mem_req_data_i  in  LINE_W  write line data.
- mem_req_rw_i  in  1  1 = write-back, 0 = line fill.
- mem_req_valid_i  in  1  request strobe; single-cycle pulse is sufficient.
- mem_data_o  out  LINE_W  read line data; held until the next read response.
- mem_ready_o  out  1  one-cycle response pulse for both reads and writes.
- busy_o  out  1  request in flight; a new request will not be accepted.
- no_rd_o  out  32  completed read count.
- no_wr_o  out  32  completed write count.
- no_drop_o  out  32  count of requests dropped while busy.

Behaviour:
- Reset: synchronous; rst_i high at a clock edge is required before operation.
  - Reset outputs: state=IDLE, mem_ready_o=0, mem_data_o=0, busy_o=0, all counters=0.
  - The array is not cleared.
  - Reset mid-operation aborts the pending request; a pending write is not committed.
- Index: line index = addr[log2(DEPTH_LINES)+3:4]; higher bits ignored (wrap) unless the optional feature is enabled.
- FSM IDLE:
  - If mem_req_valid_i is high, latch addr/data/rw into request registers.
  - Load the latency counter with (rw ? WR_LATENCY : RD_LATENCY) - 1.
  - Go to WAIT if the loaded value > 0, else RESP.
- FSM WAIT:
  - busy_o=1; counter decrements each cycle; at counter==0 go to RESP.
  - mem_req_valid_i while in WAIT: request dropped, no_drop_o increments by 1.
- FSM RESP:
  - mem_ready_o=1 for exactly this cycle; busy_o=0.
  - Write: array[idx] <= latched data on this edge; no_wr_o increments.
  - Read: mem_data_o is registered from array[idx] on entry to RESP, so it is valid in the same cycle as mem_ready_o; no_rd_o increments.
  - Back-to-back: if mem_req_valid_i is high during RESP (the L2 issues its fill in the same cycle it sees write-back ready), it is accepted exactly as in IDLE, with no bubble; otherwise go to IDLE.
- Latency: request accepted at edge T produces mem_ready_o high in cycle T+LATENCY.
- Read-after-write: a fill to the same line accepted in the write-back's RESP cycle returns the newly written data (write commits before the read array access).
- Counters wrap at 2^32; no saturation.
- busy_o is 1 in WAIT only.
- mem_data_o is unchanged by write responses.

Optional Feature:
- Macro: L2_MAIN_MEM_RANGE_CHECK_EN.
- Defined:
  - A request with any addr bit above log2(DEPTH_LINES)+3 set is out of range.
  - It still takes full latency and pulses mem_ready_o.
  - Read returns all-zero data; write is discarded (no array update).
  - Adds output mem_err_o (1 bit), high together with mem_ready_o for that response, 0 at reset.
  - Out-of-range responses are counted in no_rd_o/no_wr_o as normal.
- Undefined: no mem_err_o port; upper address bits ignored, so the index wraps modulo DEPTH_LINES.

Test Plan:
- Write then read, RD/WR_LATENCY=8: write addr 0x0000_0040, data 0x1111…_2222 → ready in cycle T+8, no_wr_o=1. Read same addr → ready at T'+8, mem_data_o=0x1111…_2222, no_rd_o=1.
- Back-to-back write-back/fill: write addr 0x80 data A; in its RESP cycle assert a read of 0x80 → accepted without bubble, ready 8 cycles later with data A; busy_o never high in the RESP cycle.
- Drop while busy: read accepted; assert valid at T+3 → no_drop_o=1, only one ready pulse; mem_data_o matches the first request.
- Reset mid-write: write 0x100 data B; assert rst_i at T+4 → outputs and counters 0. A subsequent read of 0x100 returns prior contents, not B.
- Latency corner: RD_LATENCY=1 → ready in cycle T+1; consecutive single-cycle requests each get their own ready pulse.
- Range check (macro on, DEPTH_LINES=1024): read addr 0x0001_0000 → ready with data 0, mem_err_o=1. Macro off → same request aliases to index 0 and returns array[0].
